// File: rtl/lcd_host_seq.sv
// Host-side command sequencer for an LCD controller: a small command FIFO feeding
// a handshake FSM that strobes one command at a time and waits for busy to cycle.
module lcd_host_seq #(
  parameter int CMD_W   = 3,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [CMD_W-1:0]         push_cmd,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CMD_W-1:0]         cmd,
  output logic                     cmd_valid,
  input  logic                     busy,
  input  logic                     done,
  output logic [15:0]              issued_cnt,
  output logic                     ovf,
  output logic                     err_timeout,
  output logic                     finished
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    FIN
  } state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     count_reg, count_next;
  logic [CMD_W-1:0]  mem [DEPTH];
  logic [CW-1:0]     wait_cnt_reg, wait_cnt_next;
  logic [CMD_W-1:0]  cmd_reg;
  logic              cmd_valid_reg;
  logic [15:0]       issued_cnt_reg;
  logic              ovf_reg, err_reg, fin_reg;

  logic              wr_en;
  logic              issue_go;
  logic              timeout_hit;
  logic [CMD_W-1:0]  head;

  // A push into a full FIFO is dropped even if the FSM pops in the same cycle.
  assign full  = (count_reg == LW'(DEPTH));
  assign wr_en = push && !full;
  assign head  = mem[rd_ptr_reg];

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_cmd;
    end
  end

  always_comb begin
    state_next  = state_reg;
    issue_go    = 1'b0;
    timeout_hit = 1'b0;
    if (done) begin
      state_next = FIN;
    end else begin
      case (state_reg)
        IDLE: begin
          if (count_reg != '0 && !busy) begin
            state_next = ISSUE;
            issue_go   = 1'b1;
          end
        end
        ISSUE: state_next = WAIT_HI;
        WAIT_HI: begin
          if (busy) begin
            state_next = WAIT_LO;
          end else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
            timeout_hit = 1'b1;
            state_next  = IDLE;
          end
        end
        WAIT_LO: begin
          if (!busy) begin
            state_next = IDLE;
          end else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
            timeout_hit = 1'b1;
            state_next  = IDLE;
          end
        end
        FIN:     state_next = FIN;
        default: state_next = IDLE;
      endcase
    end

    // Counter restarts from zero on every entry into a wait state.
    wait_cnt_next = '0;
    if (state_next == state_reg && (state_reg == WAIT_HI || state_reg == WAIT_LO)) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    count_next = count_reg;
    case ({wr_en, issue_go})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // The strobe and command are captured on the edge that enters ISSUE, so they
  // are visible for exactly the one cycle the FSM spends there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      wait_cnt_reg   <= '0;
      cmd_reg        <= '0;
      cmd_valid_reg  <= 1'b0;
      issued_cnt_reg <= '0;
      ovf_reg        <= 1'b0;
      err_reg        <= 1'b0;
      fin_reg        <= 1'b0;
    end else begin
      count_reg     <= count_next;
      wait_cnt_reg  <= wait_cnt_next;
      cmd_valid_reg <= issue_go;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (issue_go) begin
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
        cmd_reg        <= head;
        issued_cnt_reg <= issued_cnt_reg + 16'd1;
      end
      if (push && full) begin
        ovf_reg <= 1'b1;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
      if (done) begin
        fin_reg <= 1'b1;
      end
    end
  end

  assign level       = count_reg;
  assign cmd         = cmd_reg;
  assign cmd_valid   = cmd_valid_reg;
  assign issued_cnt  = issued_cnt_reg;
  assign ovf         = ovf_reg;
  assign err_timeout = err_reg;
  assign finished    = fin_reg;

endmodule

// File: doc/lcd_host_seq.md
LCD_HOST_SEQ -- requirements
Module: lcd_host_seq

Interface
REQ-001 Parameter CMD_W, default 3: width of each LCD_CTRL command word.
REQ-002 Parameter DEPTH, default 8: command FIFO depth; SHALL be a power of 2 and at least 2.
REQ-003 Parameter TIMEOUT, default 1024: maximum cycles allowed in each wait state.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 push  in  1  host request to enqueue push_cmd.
REQ-007 push_cmd  in  CMD_W  command to enqueue.
REQ-008 full  out  1  FIFO holds DEPTH entries.
REQ-009 level  out  log2(DEPTH)+1  number of queued entries.
REQ-010 cmd  out  CMD_W  command to LCD_CTRL.
REQ-011 cmd_valid  out  1  one-cycle command strobe to LCD_CTRL.
REQ-012 busy  in  1  LCD_CTRL busy.
REQ-013 done  in  1  LCD_CTRL completion.
REQ-014 issued_cnt  out  16  count of commands issued.
REQ-015 ovf  out  1  sticky flag: a push was dropped.
REQ-016 err_timeout  out  1  sticky flag: a wait state timed out.
REQ-017 finished  out  1  sticky flag: done was observed.

Function
REQ-018 FIFO write: push=1 and full=0 SHALL enqueue push_cmd; push=1 and full=1 SHALL drop the command and set ovf, even if a pop occurs in the same cycle.
REQ-019 FIFO pop and push in the same cycle (not full) SHALL leave level unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-020 FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, FIN.
REQ-021 IDLE -> ISSUE when level>0 and busy=0 and done=0.
REQ-022 ISSUE: cmd_valid=1 and cmd=FIFO head for exactly one cycle; head popped; issued_cnt+1 (wraps at 2^16); next state WAIT_HI.
REQ-023 cmd_valid and cmd SHALL be registered; cmd SHALL hold its last issued value when cmd_valid=0.
REQ-024 WAIT_HI -> WAIT_LO on busy=1.
REQ-025 WAIT_LO -> IDLE on busy=0.
REQ-026 Each wait state SHALL run a cycle counter cleared on entry; when TIMEOUT is reached without the exit condition, the FSM SHALL set err_timeout and return to IDLE.
REQ-027 Latency: with the FIFO empty, FSM in IDLE and busy=0, a push accepted on edge N SHALL produce cmd_valid=1 in the cycle after edge N+1.
REQ-028 done=1 in any state SHALL move the FSM to FIN and set finished; done takes priority over every other transition in the same cycle.
REQ-029 FIN SHALL be terminal until reset: no issue, cmd_valid=0; the FIFO SHALL still accept pushes.
REQ-030 A command SHALL NOT be issued while busy=1, even with the FIFO non-empty.

Reset
REQ-031 When reset=0: FSM=IDLE, FIFO empty (level=0, full=0), cmd=0, cmd_valid=0, issued_cnt=0, ovf=0, err_timeout=0, finished=0, wait counter=0.
REQ-032 Reset asserted mid-command SHALL discard all queued and in-flight commands immediately, without waiting for a clock edge.
REQ-033 Reset release SHALL take effect at the first rising clk edge after reset returns to 1.

Verification
REQ-034 Push 1, then 2, then 3; LCD_CTRL model holds busy=1 for 4 cycles after each strobe -> cmd_valid pulses with cmd=1, 2, 3 in order, each for one cycle, no strobe while busy=1, final issued_cnt=3.
REQ-035 Hold busy=1 and push 9 commands at DEPTH=8 -> full=1 after the 8th push, 9th dropped, ovf=1, level=8.
REQ-036 Issue one command; busy never rises; TIMEOUT=16 -> err_timeout=1 sixteen cycles after entering WAIT_HI, FSM back in IDLE, next queued command issued.
REQ-037 Assert done while in WAIT_LO with 2 commands queued -> finished=1, no further cmd_valid pulses, level stays 2.
REQ-038 Assert reset=0 asynchronously between clock edges while in WAIT_HI with 3 commands queued -> all outputs take their reset values before the next edge; after release, no cmd_valid pulses until a new push.
